// File: rtl/seven_segment_capture.sv
// seven_segment_capture: recovers hex digits from a multiplexed
// seven-segment bus and reports per-position changes as events.

module seven_segment_capture #(
  parameter int  DIGITS        = 4,
  parameter int  STABLE_CYCLES = 8,
  localparam int IW            = $clog2(DIGITS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [6:0]            abcdefg,
  input  logic [DIGITS-1:0]     dig_sel,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [IW-1:0]         out_index,
  output logic [3:0]            out_digit,
  output logic                  out_error,
  output logic [4*DIGITS-1:0]   digits,
  output logic [DIGITS-1:0]     digits_valid
);

  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES);
  localparam logic [CW-1:0] CNT_PRE = CW'(STABLE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [DIGITS-1:0] SEL_ONE =
    {{(DIGITS-1){1'b0}}, 1'b1};

  logic [6:0]        pat_m;
  logic [6:0]        pat_s;
  logic [DIGITS-1:0] sel_m;
  logic [DIGITS-1:0] sel_s;

  logic [6:0]        last_pat;
  logic [DIGITS-1:0] last_sel;
  logic [CW-1:0]     cnt;

  logic              onehot;
  logic              same;
  logic              capture;

  logic [IW-1:0]     cap_idx;
  logic [3:0]        cap_dig;
  logic              cap_err;

  logic [3:0]        st_dig [DIGITS];
  logic [DIGITS-1:0] st_err;
  logic [DIGITS-1:0] st_vld;

  logic              new_ev;
  logic              slot_free;
  logic [DIGITS-1:0] pending;
  logic              pend_any;
  logic [IW-1:0]     pend_idx;

  // Two-flop synchronizer on the segment and strobe lines
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pat_m <= '0;
      pat_s <= '0;
      sel_m <= '0;
      sel_s <= '0;
    end else begin
      pat_m <= abcdefg;
      pat_s <= pat_m;
      sel_m <= dig_sel;
      sel_s <= sel_m;
    end
  end

  // Qualify the synchronized sample: one-hot strobe, unchanged pair
  always_comb begin
    onehot = (sel_s != '0) &&
             ((sel_s & (sel_s - SEL_ONE)) == '0);
    same   = (sel_s == last_sel) && (pat_s == last_pat);
    capture = onehot && same &&
              (cnt == CNT_PRE) && (pat_s != 7'b0);
  end

  // Stability window: one capture per run of identical samples
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_pat <= '0;
      last_sel <= '0;
      cnt      <= '0;
    end else if (!onehot) begin
      last_pat <= pat_s;
      last_sel <= sel_s;
      cnt      <= '0;
    end else if (!same) begin
      last_pat <= pat_s;
      last_sel <= sel_s;
      cnt      <= CNT_ONE;
    end else if (cnt == CNT_PRE) begin
      cnt      <= CNT_MAX;
    end else if (cnt < CNT_MAX) begin
      cnt      <= cnt + CNT_ONE;
    end
  end

  // Glyph-to-hex encoder; unknown lit patterns flag an error
  always_comb begin
    cap_dig = 4'h0;
    cap_err = 1'b0;
    case (pat_s)
      7'b1111110: cap_dig = 4'h0;
      7'b0110000: cap_dig = 4'h1;
      7'b1101101: cap_dig = 4'h2;
      7'b1111001: cap_dig = 4'h3;
      7'b0110011: cap_dig = 4'h4;
      7'b1011011: cap_dig = 4'h5;
      7'b1011111: cap_dig = 4'h6;
      7'b1110010: cap_dig = 4'h7;
      7'b1111111: cap_dig = 4'h8;
      7'b1111011: cap_dig = 4'h9;
      7'b1110111: cap_dig = 4'hA;
      7'b0011111: cap_dig = 4'hB;
      7'b1001110: cap_dig = 4'hC;
      7'b0111101: cap_dig = 4'hD;
      7'b1001111: cap_dig = 4'hE;
      7'b1000111: cap_dig = 4'hF;
      default:    cap_err = 1'b1;
    endcase
  end

  // Strobe position of the sample being captured
  always_comb begin
    cap_idx = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (sel_s[i]) cap_idx = IW'(i);
    end
  end

  // A capture is an event if it is first or changes the entry
  always_comb begin
    new_ev = capture &&
             (!st_vld[cap_idx] ||
              (st_err[cap_idx] != cap_err) ||
              (st_dig[cap_idx] != cap_dig));
  end

  // Per-position store of {error, digit}
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DIGITS; i++) st_dig[i] <= '0;
      st_err <= '0;
      st_vld <= '0;
    end else if (new_ev) begin
      st_dig[cap_idx] <= cap_dig;
      st_err[cap_idx] <= cap_err;
      st_vld[cap_idx] <= 1'b1;
    end
  end

  // Flatten the store onto the digits bus
  always_comb begin
    digits = '0;
    for (int i = 0; i < DIGITS; i++) begin
      digits[4*i +: 4] = st_dig[i];
    end
    digits_valid = st_vld;
  end

  // Lowest-index pending position, drained first
  always_comb begin
    pend_any = 1'b0;
    pend_idx = '0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      if (pending[i]) begin
        pend_any = 1'b1;
        pend_idx = IW'(i);
      end
    end
  end

  assign slot_free = !out_valid || out_ready;

  // Event slot: fresh capture first, then coalesced pending entries
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_index <= '0;
      out_digit <= '0;
      out_error <= 1'b0;
      pending   <= '0;
    end else if (slot_free) begin
      unique case (1'b1)
        new_ev: begin
          out_valid <= 1'b1;
          out_index <= cap_idx;
          out_digit <= cap_dig;
          out_error <= cap_err;
        end
        pend_any: begin
          out_valid         <= 1'b1;
          out_index         <= pend_idx;
          out_digit         <= st_dig[pend_idx];
          out_error         <= st_err[pend_idx];
          pending[pend_idx] <= 1'b0;
        end
        default: out_valid <= 1'b0;
      endcase
    end else if (new_ev) begin
      pending[cap_idx] <= 1'b1;
    end
  end

endmodule

// File: tb/tb_seven_segment_capture.sv
// tb_seven_segment_capture: directed vectors for the
// seven-segment capture block.

module tb_seven_segment_capture;

  localparam logic [6:0] G0   = 7'b1111110;
  localparam logic [6:0] G3   = 7'b1111001;
  localparam logic [6:0] G5   = 7'b1011011;
  localparam logic [6:0] G7   = 7'b1110010;
  localparam logic [6:0] G1   = 7'b0110000;
  localparam logic [6:0] G8   = 7'b1111111;
  localparam logic [6:0] G9   = 7'b1111011;
  localparam logic [6:0] GA   = 7'b1110111;
  localparam logic [6:0] GB   = 7'b0011111;
  localparam logic [6:0] GC   = 7'b1001110;
  localparam logic [6:0] GD   = 7'b0111101;
  localparam logic [6:0] DASH = 7'b0000001;

  logic        clk = 1'b0;
  logic        rst;
  logic [6:0]  abcdefg;
  logic [3:0]  dig_sel;
  logic        out_valid;
  logic        out_ready;
  logic [1:0]  out_index;
  logic [3:0]  out_digit;
  logic        out_error;
  logic [15:0] digits;
  logic [3:0]  digits_valid;

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;
  int c0;

  int q_idx[$];
  int q_dig[$];
  int q_err[$];
  int q_cyc[$];

  seven_segment_capture dut (
    .clk          (clk),
    .rst          (rst),
    .abcdefg      (abcdefg),
    .dig_sel      (dig_sel),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_index    (out_index),
    .out_digit    (out_digit),
    .out_error    (out_error),
    .digits       (digits),
    .digits_valid (digits_valid)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      q_idx.push_back(int'(out_index));
      q_dig.push_back(int'(out_digit));
      q_err.push_back(int'(out_error));
      q_cyc.push_back(cyc);
    end
  end

  task automatic chk(input string tag, input int got,
                     input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d",
                  tag, got, exp);
  endtask

  function automatic int at(input int q[$], input int i);
    if (i < q.size()) return q[i];
    return -1;
  endfunction

  task automatic hold(input logic [3:0] s,
                      input logic [6:0] p, input int n);
    dig_sel = s;
    abcdefg = p;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic flush();
    q_idx.delete();
    q_dig.delete();
    q_err.delete();
    q_cyc.delete();
  endtask

  initial begin
    rst       = 1'b1;
    abcdefg   = '0;
    dig_sel   = '0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid",  int'(out_valid),    0);
    chk("rst_digits", int'(digits),       0);
    chk("rst_dvalid", int'(digits_valid), 0);
    chk("rst_index",  int'(out_index),    0);
    rst = 1'b0;
    hold(4'b0000, 7'b0, 2);

    // basic capture and latency
    flush();
    c0 = cyc;
    hold(4'b0001, G3, 12);
    hold(4'b0000, 7'b0, 3);
    chk("basic_n",    q_idx.size(),     1);
    chk("basic_idx",  at(q_idx, 0),     0);
    chk("basic_dig",  at(q_dig, 0),     3);
    chk("basic_err",  at(q_err, 0),     0);
    chk("basic_lat",  at(q_cyc, 0),     c0 + 10);
    chk("basic_d0",   int'(digits[3:0]), 3);
    chk("basic_dv",   int'(digits_valid), 1);

    // full scan, then identical rescan
    flush();
    hold(4'b0001, GA, 10);
    hold(4'b0010, GB, 10);
    hold(4'b0100, GC, 10);
    hold(4'b1000, GD, 10);
    hold(4'b0000, 7'b0, 3);
    chk("scan_n", q_idx.size(), 4);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("scan_idx%0d", i), at(q_idx, i), i);
      chk($sformatf("scan_dig%0d", i), at(q_dig, i), 10 + i);
    end
    chk("scan_digits", int'(digits), 16'hDCBA);
    chk("scan_dv", int'(digits_valid), 15);
    flush();
    hold(4'b0001, GA, 10);
    hold(4'b0010, GB, 10);
    hold(4'b0100, GC, 10);
    hold(4'b1000, GD, 10);
    hold(4'b0000, 7'b0, 3);
    chk("rescan_n", q_idx.size(), 0);

    // glitch rejection and multi-hot strobe
    flush();
    hold(4'b0010, G1, 5);
    hold(4'b0010, G8, 10);
    hold(4'b0000, 7'b0, 3);
    chk("glitch_n",   q_idx.size(), 1);
    chk("glitch_idx", at(q_idx, 0), 1);
    chk("glitch_dig", at(q_dig, 0), 8);
    flush();
    hold(4'b0011, G3, 20);
    hold(4'b0000, 7'b0, 3);
    chk("multihot_n", q_idx.size(), 0);

    // dash error, then blank
    flush();
    hold(4'b0100, DASH, 10);
    hold(4'b0000, 7'b0, 3);
    chk("dash_n",   q_idx.size(), 1);
    chk("dash_idx", at(q_idx, 0), 2);
    chk("dash_dig", at(q_dig, 0), 0);
    chk("dash_err", at(q_err, 0), 1);
    chk("dash_d2",  int'(digits[11:8]), 0);
    flush();
    hold(4'b0100, 7'b0, 12);
    hold(4'b0000, 7'b0, 3);
    chk("blank_n",  q_idx.size(), 0);
    chk("blank_dv", int'(digits_valid), 15);

    // backpressure and coalesced pending order
    flush();
    out_ready = 1'b0;
    hold(4'b1000, G5, 10);
    chk("bp_valid", int'(out_valid), 1);
    chk("bp_idx",   int'(out_index), 3);
    chk("bp_dig",   int'(out_digit), 5);
    hold(4'b0010, G7, 10);
    hold(4'b1000, G9, 10);
    hold(4'b0000, 7'b0, 2);
    chk("bp_hold_idx", int'(out_index), 3);
    chk("bp_hold_dig", int'(out_digit), 5);
    chk("bp_d3",       int'(digits[15:12]), 9);
    chk("bp_d1",       int'(digits[7:4]), 7);
    out_ready = 1'b1;
    hold(4'b0000, 7'b0, 5);
    chk("bp_n",    q_idx.size(), 3);
    chk("bp_idx0", at(q_idx, 0), 3);
    chk("bp_dig0", at(q_dig, 0), 5);
    chk("bp_idx1", at(q_idx, 1), 1);
    chk("bp_dig1", at(q_dig, 1), 7);
    chk("bp_idx2", at(q_idx, 2), 3);
    chk("bp_dig2", at(q_dig, 2), 9);
    chk("bp_seq1", at(q_cyc, 1), at(q_cyc, 0) + 1);
    chk("bp_seq2", at(q_cyc, 2), at(q_cyc, 0) + 2);
    chk("bp_idle", int'(out_valid), 0);

    // reset with a held event and a pending entry
    out_ready = 1'b0;
    hold(4'b0001, G8, 10);
    hold(4'b0010, G3, 10);
    hold(4'b0000, 7'b0, 2);
    chk("pre_rst_valid", int'(out_valid), 1);
    chk("pre_rst_idx",   int'(out_index), 0);
    rst = 1'b1;
    #2;
    chk("mid_rst_valid",  int'(out_valid), 0);
    chk("mid_rst_digit",  int'(out_digit), 0);
    chk("mid_rst_digits", int'(digits), 0);
    chk("mid_rst_dv",     int'(digits_valid), 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    out_ready = 1'b1;
    flush();
    hold(4'b0000, 7'b0, 10);
    chk("post_rst_n", q_idx.size(), 0);
    hold(4'b0100, 7'b0, 12);
    hold(4'b0000, 7'b0, 3);
    chk("post_blank_n",  q_idx.size(), 0);
    chk("post_blank_dv", int'(digits_valid), 0);
    hold(4'b0100, G0, 10);
    hold(4'b0000, 7'b0, 3);
    chk("post_zero_n",   q_idx.size(), 1);
    chk("post_zero_idx", at(q_idx, 0), 2);
    chk("post_zero_dig", at(q_dig, 0), 0);
    chk("post_zero_err", at(q_err, 0), 0);
    chk("post_zero_dv",  int'(digits_valid), 4);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
